// File: rtl/pop_byte_reader_if.sv
// Byte-stream handshake between the population reader and its downstream consumer.
interface pop_byte_reader_if #(
  parameter int IDX_W = 10
);
  logic [7:0]       out_byte;
  logic [IDX_W-1:0] out_index;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output out_byte,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_byte,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pop_byte_reader.sv
// Snapshots a packed population vector and streams it out oldest (most significant) byte first
// over a valid/ready handshake, pulsing done one cycle after the final transfer.
module pop_byte_reader #(
  parameter int NUM_BYTES = 937,
  parameter int POP_W     = 7501,
  parameter int IDX_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [POP_W-1:0]   population,
  pop_byte_reader_if.master  ob,
  output logic               busy,
  output logic               done
);

  localparam int SNAP_W = 8 * NUM_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [7:0]        byte_q, byte_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer_s;

  // Bits above the streamed region are deliberately never read.
  generate
    if (POP_W > SNAP_W) begin : g_spare
      logic unused_pop_s;
      assign unused_pop_s = ^population[POP_W-1:SNAP_W];
    end
  endgenerate

  assign xfer_s = valid_q && ob.out_ready;

  // Next-state and next-output computation for the readout FSM.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    byte_d  = byte_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = population[SNAP_W-1:0];
          index_d = {IDX_W{1'b0}};
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        byte_d  = snap_q[SNAP_W-1 -: 8];
        snap_d  = snap_q << 8;
        index_d = {IDX_W{1'b0}};
        valid_d = 1'b1;
        last_d  = (NUM_BYTES == 1);
        busy_d  = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer_s && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (xfer_s && (index_q < LAST_IDX)) begin
          // The snapshot is pre-shifted, so its top byte is always the next one due.
          byte_d  = snap_q[SNAP_W-1 -: 8];
          snap_d  = snap_q << 8;
          index_d = index_q + IDX_W'(1);
          last_d  = ((index_q + IDX_W'(1)) == LAST_IDX);
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= {SNAP_W{1'b0}};
      byte_q  <= 8'h00;
      index_q <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      byte_q  <= byte_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ob.out_byte  = byte_q;
  assign ob.out_index = index_q;
  assign ob.out_valid = valid_q;
  assign ob.out_last  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pop_byte_reader.sv
// Directed bench for pop_byte_reader: a 4-byte, a full-size 937-byte and a 1-byte instance.
module tb_pop_byte_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, start_b, start_c;
  logic [34:0]   pop_a;
  logic [7500:0] pop_b;
  logic [7:0]    pop_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;

  pop_byte_reader_if #(.IDX_W(3))  if_a ();
  pop_byte_reader_if #(.IDX_W(10)) if_b ();
  pop_byte_reader_if #(.IDX_W(1))  if_c ();

  pop_byte_reader #(.NUM_BYTES(4), .POP_W(35), .IDX_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .population(pop_a),
    .ob(if_a), .busy(busy_a), .done(done_a)
  );

  pop_byte_reader #(.NUM_BYTES(937), .POP_W(7501), .IDX_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .population(pop_b),
    .ob(if_b), .busy(busy_b), .done(done_b)
  );

  pop_byte_reader #(.NUM_BYTES(1), .POP_W(8), .IDX_W(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .population(pop_c),
    .ob(if_c), .busy(busy_c), .done(done_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one readout on the 4-byte instance; rpat bit i is out_ready for valid cycle i.
  task automatic stream_a(input logic [34:0] pop, input logic [31:0] exp, input logic [15:0] rpat,
                          input bit poke, input bit start_at_done, input int want_done_k);
    int n, vi, dones, last_k, done_k;
    n = 0; vi = 0; dones = 0; last_k = -1; done_k = -1;
    @(negedge clk);
    pop_a = pop;
    start_a = 1'b1;
    if_a.out_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (poke && (k == 4)) begin
        pop_a = '0;
        start_a = 1'b1;
      end
      if (if_a.out_valid) begin
        if_a.out_ready = (vi < 16) ? rpat[vi] : 1'b1;
        vi++;
        if (n < 4) begin
          check_eq("a_byte", if_a.out_byte, exp[8*(3-n) +: 8]);
          check_eq("a_index", if_a.out_index, n);
          check_eq("a_last", if_a.out_last, (n == 3));
        end else begin
          check_eq("a_overrun", n, 3);
        end
        if (if_a.out_ready) begin
          n++;
          last_k = k;
        end
      end else begin
        if_a.out_ready = 1'b1;
      end
      if (done_a) begin
        dones++;
        if (done_k < 0) done_k = k;
        if (start_at_done) start_a = 1'b1;
      end
      if ((done_k > 0) && (k >= done_k + 2)) break;
    end
    start_a = 1'b0;
    check_eq("a_xfers", n, 4);
    check_eq("a_dones", dones, 1);
    check_eq("a_done_after_last", done_k, last_k + 1);
    if (want_done_k > 0) check_eq("a_done_cycle", done_k, want_done_k);
    check_eq("a_idle_busy", busy_a, 1'b0);
    check_eq("a_idle_valid", if_a.out_valid, 1'b0);
  endtask

  logic [7:0] mem_b [937];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int n, done_k;

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    pop_a = '0; pop_b = '0; pop_c = '0;
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0; if_c.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_a_valid", if_a.out_valid, 1'b0);
    check_eq("rst_a_byte", if_a.out_byte, 8'h00);
    check_eq("rst_a_index", if_a.out_index, 3'd0);
    check_eq("rst_a_last", if_a.out_last, 1'b0);
    check_eq("rst_a_busy", busy_a, 1'b0);
    check_eq("rst_a_done", done_a, 1'b0);
    check_eq("rst_b_valid", if_b.out_valid, 1'b0);
    check_eq("rst_c_busy", busy_c, 1'b0);
    rst_n = 1'b1;

    // Test 1: ready always high, start during DONE must be ignored.
    stream_a(35'h4_DEADBEEF, 32'hDEADBEEF, 16'hFFFF, 1'b0, 1'b1, 6);
    // Test 2: ready pattern 1,0,0,1,0,1,1.
    stream_a(35'h4_DEADBEEF, 32'hDEADBEEF, 16'hFFE9, 1'b0, 1'b0, 0);
    // Test 3: population cleared and start re-pulsed mid-stream.
    stream_a(35'h4_DEADBEEF, 32'hDEADBEEF, 16'hFFFF, 1'b1, 1'b0, 6);

    // Test 4: reset after AD is accepted.
    @(negedge clk);
    pop_a = 35'h4_DEADBEEF;
    start_a = 1'b1;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check_eq("r4_byte0", if_a.out_byte, 8'hDE);
    @(negedge clk);
    check_eq("r4_byte1", if_a.out_byte, 8'hAD);
    @(negedge clk);
    check_eq("r4_byte2", if_a.out_byte, 8'hBE);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("r4_valid", if_a.out_valid, 1'b0);
    check_eq("r4_busy", busy_a, 1'b0);
    check_eq("r4_index", if_a.out_index, 3'd0);
    check_eq("r4_done", done_a, 1'b0);
    @(negedge clk);
    check_eq("r4_done_after", done_a, 1'b0);
    check_eq("r4_valid_after", if_a.out_valid, 1'b0);
    stream_a(35'h0_01020304, 32'h01020304, 16'hFFFF, 1'b0, 1'b0, 6);

    // Test 5: full-size instance, LFSR-generated bytes, spare top bits set.
    v = 8'h5A;
    for (int k = 0; k < 937; k++) begin
      mem_b[k] = v;
      pop_b[8*(936-k) +: 8] = v;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    pop_b[7500:7496] = 5'h1F;
    n = 0;
    done_k = -1;
    @(negedge clk);
    start_b = 1'b1;
    if_b.out_ready = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (if_b.out_valid) begin
        if (n < 937) begin
          check_eq("b_byte", if_b.out_byte, mem_b[n]);
          check_eq("b_index", if_b.out_index, n);
          check_eq("b_last", if_b.out_last, (n == 936));
          if (n == 936) check_eq("b_final_byte", if_b.out_byte, pop_b[7:0]);
        end else begin
          check_eq("b_overrun", n, 936);
        end
        n++;
      end
      if (done_b) begin
        done_k = k;
        break;
      end
    end
    check_eq("b_xfers", n, 937);
    check_eq("b_done_cycle", done_k, 939);

    // Test 6: single-byte instance.
    @(negedge clk);
    pop_c = 8'hA5;
    start_c = 1'b1;
    if_c.out_ready = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    check_eq("c_load_valid", if_c.out_valid, 1'b0);
    check_eq("c_load_busy", busy_c, 1'b1);
    @(negedge clk);
    check_eq("c_valid", if_c.out_valid, 1'b1);
    check_eq("c_last", if_c.out_last, 1'b1);
    check_eq("c_byte", if_c.out_byte, 8'hA5);
    check_eq("c_index", if_c.out_index, 1'b0);
    @(negedge clk);
    check_eq("c_done", done_c, 1'b1);
    check_eq("c_done_valid", if_c.out_valid, 1'b0);
    @(negedge clk);
    check_eq("c_idle_done", done_c, 1'b0);
    check_eq("c_idle_busy", busy_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
